// File: rtl/fetch_pair_queue.sv
// Dual-issue fetch buffer: issues two-word instruction reads, queues {pc, inst}
// entries and presents the two oldest to the pair dependency checker.
module fetch_pair_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [12:0] RESET_PC = 13'd0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [1:0]  take,
   input  logic        redirect,
   input  logic [12:0] redirect_pc,
   output logic        imem_req,
   output logic [12:0] imem_addr,
   input  logic [31:0] imem_rdata1,
   input  logic [31:0] imem_rdata2,
   output logic        valid1,
   output logic        valid2,
   output logic [12:0] pc1_out,
   output logic [31:0] inst1_out,
   output logic [12:0] pc2_out,
   output logic [31:0] inst2_out
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = PW + 3;

   logic [12:0]   pc_mem   [DEPTH];
   logic [31:0]   inst_mem [DEPTH];

   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [12:0]   fetch_pc_q, fetch_pc_d;
   logic [12:0]   req_pc_q, req_pc_d;
   logic          inflight_q;

   logic [1:0]    take_sat;
   logic [1:0]    eff_take;
   logic [CW-1:0] count_after;
   logic [SW-1:0] need;
   logic          resp_ok;
   logic [12:0]   redirect_base;
   logic [PW-1:0] rd_ptr_nxt;
   logic [PW-1:0] wr_ptr_nxt;

   assign redirect_base = redirect_pc & 13'h1FFC;
   assign resp_ok       = inflight_q && !redirect;
   assign rd_ptr_nxt    = rd_ptr_q + PW'(1);
   assign wr_ptr_nxt    = wr_ptr_q + PW'(1);

   always_comb begin
      take_sat = (take == 2'd3) ? 2'd2 : take;
      eff_take = 2'd0;
      if (count_q >= CW'(2)) begin
         eff_take = take_sat;
      end else if (count_q == CW'(1)) begin
         eff_take = (take_sat != 2'd0) ? 2'd1 : 2'd0;
      end
      count_after = count_q - CW'(eff_take);
      // Reserve room for the response already in flight plus the one requested now.
      need = SW'(count_after) + (inflight_q ? SW'(2) : SW'(0)) + SW'(2);
      imem_req  = !RST && !redirect && (need <= SW'(DEPTH));
      imem_addr = imem_req ? fetch_pc_q : 13'd0;
   end

   always_comb begin
      count_d    = count_after + (resp_ok ? CW'(2) : CW'(0));
      rd_ptr_d   = rd_ptr_q + PW'(eff_take);
      wr_ptr_d   = resp_ok ? (wr_ptr_q + PW'(2)) : wr_ptr_q;
      fetch_pc_d = imem_req ? (fetch_pc_q + 13'd8) : fetch_pc_q;
      req_pc_d   = imem_req ? fetch_pc_q : req_pc_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= 13'd0;
         inflight_q <= 1'b0;
      end else if (redirect) begin
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         fetch_pc_q <= redirect_base;
         req_pc_q   <= 13'd0;
         inflight_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= imem_req;
      end
   end

   // Storage needs no reset: every read is gated by the occupancy count.
   always_ff @(posedge CLK) begin
      if (!RST && resp_ok) begin
         pc_mem[wr_ptr_q]     <= req_pc_q;
         inst_mem[wr_ptr_q]   <= imem_rdata1;
         pc_mem[wr_ptr_nxt]   <= req_pc_q + 13'd4;
         inst_mem[wr_ptr_nxt] <= imem_rdata2;
      end
   end

   always_comb begin
      valid1    = (count_q != '0);
      valid2    = (count_q >= CW'(2));
      pc1_out   = valid1 ? pc_mem[rd_ptr_q]     : 13'd0;
      inst1_out = valid1 ? inst_mem[rd_ptr_q]   : 32'd0;
      pc2_out   = valid2 ? pc_mem[rd_ptr_nxt]   : 13'd0;
      inst2_out = valid2 ? inst_mem[rd_ptr_nxt] : 32'd0;
   end

endmodule
